// File: rtl/mem_responder.sv
// mem_responder: 32-bit word store behind a fixed-latency request/response handshake.
// Define MEM_RESP_ADDR_CHECK_EN to flag misaligned or out-of-range addresses via AddrErr.
module mem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    input  logic [3:0]  ByteEn,
    output logic        Ready,
    output logic [31:0] Dataout,
    output logic        Busy,
    output logic        AddrErr
);
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] dout_q, dout_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic                  enter_resp;
    logic                  in_idle;
    logic                  cur_wr;
    logic [31:0]           cur_addr;
    logic [31:0]           cur_wdata;
    logic [3:0]            cur_be;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           lane_mask;
    logic [31:0]           rd_word;
    logic                  addr_bad;
    logic                  mem_we;

    // With WAIT=0 the response is entered on the accept edge itself,
    // so the live inputs stand in for the not-yet-captured fields.
    assign in_idle   = (state_q == ST_IDLE);
    assign cur_wr    = in_idle ? Wr      : wr_q;
    assign cur_addr  = in_idle ? Address : addr_q;
    assign cur_wdata = in_idle ? Datain  : wdata_q;
    assign cur_be    = in_idle ? ByteEn  : be_q;
    assign idx       = cur_addr[DEPTH_LOG2+1:2];
    assign rd_word   = mem_q[idx];

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{cur_be[i]}};
        end
    end

`ifdef MEM_RESP_ADDR_CHECK_EN
    assign addr_bad = (cur_addr[1:0] != 2'b00) ||
                      ((cur_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
    logic unused_addr;
    assign addr_bad    = 1'b0;
    assign unused_addr = ^{cur_addr[31:DEPTH_LOG2+2], cur_addr[1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        dout_d     = '0;
        err_d      = 1'b0;
        enter_resp = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    wr_d    = Wr;
                    addr_d  = Address;
                    wdata_d = Datain;
                    be_d    = ByteEn;
                    cnt_d   = WAIT_CNT;
                    if (WAIT_CNT == 4'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enter_resp) begin
            err_d = addr_bad;
            if (!cur_wr && !addr_bad) begin
                dout_d = rd_word & lane_mask;
            end
        end
    end

    assign mem_we = enter_resp && cur_wr && !addr_bad && Reset_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem_q[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    assign Ready   = (state_q == ST_RESP);
    assign Busy    = !in_idle;
    assign Dataout = dout_q;
    assign AddrErr = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT=2, DEPTH_LOG2=8).
// Vector table plus hand-written reset-abort and back-to-back sequences.
module tb_mem_responder;
    localparam int WAIT = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Req = 1'b0;
    logic        Wr = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Datain = '0;
    logic [3:0]  ByteEn = '0;
    logic        Ready;
    logic [31:0] Dataout;
    logic        Busy;
    logic        AddrErr;

    mem_responder #(.DEPTH_LOG2(8), .WAIT(WAIT)) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .Req(Req),
        .Wr(Wr),
        .Address(Address),
        .Datain(Datain),
        .ByteEn(ByteEn),
        .Ready(Ready),
        .Dataout(Dataout),
        .Busy(Busy),
        .AddrErr(AddrErr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] be,
                                input logic [31:0] exp_d, input logic exp_e);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.be = be;
        v.exp_d = exp_d; v.exp_e = exp_e;
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic do_req(input vec_t v, input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        Req = 1'b1; Wr = v.wr; Address = v.addr; Datain = v.data; ByteEn = v.be;
        exp_q.push_back('{d: v.exp_d, e: v.exp_e});
        @(posedge Clk);
        #1;
        Req = 1'b0; Wr = ~v.wr; Address = ~v.addr; Datain = ~v.data; ByteEn = ~v.be;
        lat = 0;
        seen = 0;
        while (!seen && lat < 10) begin
            @(negedge Clk);
            lat++;
            if (Ready) seen = 1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no Ready within %0d cycles", tag, lat);
            void'(exp_q.pop_front());
            return;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(WAIT + 1));
        chk({tag, "_busy"}, {31'b0, Busy}, 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_sb: Ready with empty scoreboard, expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, Dataout, e.d);
            chk({tag, "_err"}, {31'b0, AddrErr}, {31'b0, e.e});
        end
        @(negedge Clk);
        chk({tag, "_idle"}, {Ready, Busy, AddrErr}, 32'd0);
        chk({tag, "_dout0"}, Dataout, 32'd0);
    endtask

    initial begin
        vecs.push_back(mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0,        4'hF, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h10, 32'h0000AA00, 4'h2, 32'h0, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0,        4'hF, 32'hDEADAAEF, 0));
        vecs.push_back(mk(0, 32'h10, 32'h0,        4'hC, 32'hDEAD0000, 0));
        vecs.push_back(mk(1, 32'h14, 32'h11223344, 4'hF, 32'h0, 0));
        vecs.push_back(mk(1, 32'h14, 32'hFFFFFFFF, 4'h0, 32'h0, 0));
        vecs.push_back(mk(0, 32'h14, 32'h0,        4'hF, 32'h11223344, 0));
        vecs.push_back(mk(0, 32'h14, 32'h0,        4'h5, 32'h00220044, 0));
`ifdef MEM_RESP_ADDR_CHECK_EN
        vecs.push_back(mk(1, 32'h12,  32'hFFFFFFFF, 4'hF, 32'h0, 1));
        vecs.push_back(mk(1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1));
        vecs.push_back(mk(0, 32'h10,  32'h0,        4'hF, 32'hDEADAAEF, 0));
        vecs.push_back(mk(0, 32'h13,  32'h0,        4'hF, 32'h0, 1));
`else
        vecs.push_back(mk(1, 32'h400, 32'h12345678, 4'hF, 32'h0, 0));
        vecs.push_back(mk(0, 32'h0,   32'h0,        4'hF, 32'h12345678, 0));
        vecs.push_back(mk(0, 32'h13,  32'h0,        4'hF, 32'hDEADAAEF, 0));
`endif

        #2 Reset_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, Ready}, 32'd0);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_err", {31'b0, AddrErr}, 32'd0);
        chk("rst_dout", Dataout, 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            do_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during WAIT aborts a pending write.
        Req = 1'b1; Wr = 1'b1; Address = 32'h10; Datain = 32'hFFFFFFFF; ByteEn = 4'hF;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        chk("abort_busy_before", {31'b0, Busy}, 32'd1);
        #1 Reset_n = 1'b0;
        #1;
        chk("abort_busy_now", {31'b0, Busy}, 32'd0);
        chk("abort_ready_now", {31'b0, Ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk($sformatf("abort_ready_rst%0d", i), {31'b0, Ready}, 32'd0);
        end
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk($sformatf("abort_ready_post%0d", i), {Ready, Busy}, 32'd0);
        end
        do_req(mk(0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 0), "abort_read");

        // Req held high: one response every WAIT+2 cycles.
        Req = 1'b1; Wr = 1'b0; Address = 32'h10; Datain = 32'h0; ByteEn = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i == 19) Req = 1'b0;
            chk($sformatf("b2b_ready%0d", i), {31'b0, Ready},
                {31'b0, ((i % 4) == 2)});
            chk($sformatf("b2b_busy%0d", i), {31'b0, Busy},
                {31'b0, ((i % 4) != 3)});
            if ((i % 4) == 2) begin
                chk($sformatf("b2b_data%0d", i), Dataout, 32'hDEADAAEF);
            end
        end
        @(negedge Clk);
        chk("b2b_end", {Ready, Busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
